branch_predictor: RTL

//  Fetch-side predictor paired with the execute-stage branch calculator. It produces the prediction
//  (taken + target) that the calculator later checks, and it trains on the calculator's resolved

---
 rtl/rat_branch_pkg.sv | 40 ++++
 rtl/branch_predictor_if.sv | 34 +++
 rtl/rat_return_stack.sv | 53 +++++
 rtl/branch_predictor.sv | 94 +++++++++
 4 files changed

// File: rtl/rat_branch_pkg.sv
// Shared branch-type codes and 2-bit counter encodings used by the predictor and branch calculator.
`default_nettype none
package rat_branch_pkg;

  typedef enum logic [3:0] {
    BR_NONE  = 4'd0,
    BR_BRCC  = 4'd1,
    BR_BRCS  = 4'd2,
    BR_BREQ  = 4'd3,
    BR_BRN   = 4'd4,
    BR_BRNE  = 4'd5,
    BR_CALL  = 4'd6,
    BR_RET   = 4'd7,
    BR_RETID = 4'd8,
    BR_RETIE = 4'd9
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam logic [1:0] CTR_RESET = WNT;

  function automatic logic br_is_cond(input logic [3:0] t);
    return (t == BR_BRCC) || (t == BR_BRCS) || (t == BR_BREQ) || (t == BR_BRNE);
  endfunction

  function automatic logic br_is_ret(input logic [3:0] t);
    return (t == BR_RET) || (t == BR_RETID) || (t == BR_RETIE);
  endfunction

  function automatic logic br_is_branch(input logic [3:0] t);
    return (t >= BR_BRCC) && (t <= BR_RETIE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and resolve-side training signals of the branch predictor.
`default_nettype none
interface branch_predictor_if #(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4,
  parameter int STAT_W    = 16
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [PC_W-1:0]   PC_F;
  logic [3:0]        BR_TYPE_F;
  logic [PC_W-1:0]   IMM_ADDR_F;
  logic              PREDICT_TAKEN;
  logic [PC_W-1:0]   PREDICT_TARGET;
  logic              RES_VALID;
  logic [PC_W-1:0]   RES_PC;
  logic [3:0]        RES_TYPE;
  logic              RES_TAKEN;
  logic              RES_MISS;
  logic [CNT_W-1:0]  RAS_COUNT;
  logic [STAT_W-1:0] PRED_COUNT;
  logic [STAT_W-1:0] MISS_COUNT;

  modport master (
    output PC_F, BR_TYPE_F, IMM_ADDR_F, RES_VALID, RES_PC, RES_TYPE, RES_TAKEN, RES_MISS,
    input  PREDICT_TAKEN, PREDICT_TARGET, RAS_COUNT, PRED_COUNT, MISS_COUNT
  );

  modport slave (
    input  PC_F, BR_TYPE_F, IMM_ADDR_F, RES_VALID, RES_PC, RES_TYPE, RES_TAKEN, RES_MISS,
    output PREDICT_TAKEN, PREDICT_TARGET, RAS_COUNT, PRED_COUNT, MISS_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/rat_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry, a pop when empty is ignored.
`default_nettype none
module rat_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [W-1:0]               push_data,
  output logic      [W-1:0]               top,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next free slot; the power-of-2 depth lets it wrap onto the oldest entry.
  assign top   = mem_q[ptr_q - PTR_W'(1)];
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter table, commit-time return stack and resolve statistics.
`default_nettype none
module branch_predictor
  import rat_branch_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int IDX_W     = 5,
  parameter int RAS_DEPTH = 4,
  parameter int STAT_W    = 16
) (
  input  wire logic          CLK,
  input  wire logic          RESET_N,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CNT_W   = $clog2(RAS_DEPTH) + 1;

  logic [1:0]        ctr_q [ENTRIES];
  logic [1:0]        ctr_d [ENTRIES];
  logic [STAT_W-1:0] pred_cnt_q, pred_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic              ras_push, ras_pop;
  logic [PC_W-1:0]   ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic [IDX_W-1:0]  fetch_idx, res_idx;

  assign fetch_idx = bp.PC_F[IDX_W-1:0];
  assign res_idx   = bp.RES_PC[IDX_W-1:0];
  assign ras_push  = bp.RES_VALID && (bp.RES_TYPE == BR_CALL);
  assign ras_pop   = bp.RES_VALID && br_is_ret(bp.RES_TYPE);

  rat_return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (bp.RES_PC + PC_W'(1)),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Prediction reads only pre-edge state, so a same-cycle update is never bypassed.
  always_comb begin
    bp.PREDICT_TAKEN  = 1'b0;
    bp.PREDICT_TARGET = bp.IMM_ADDR_F;
    if (br_is_cond(bp.BR_TYPE_F)) begin
      bp.PREDICT_TAKEN = ctr_q[fetch_idx][1];
    end else if ((bp.BR_TYPE_F == BR_BRN) || (bp.BR_TYPE_F == BR_CALL)) begin
      bp.PREDICT_TAKEN = 1'b1;
    end else if (br_is_ret(bp.BR_TYPE_F) && (ras_count != '0)) begin
      bp.PREDICT_TAKEN  = 1'b1;
      bp.PREDICT_TARGET = ras_top;
    end
  end

  assign bp.RAS_COUNT  = ras_count;
  assign bp.PRED_COUNT = pred_cnt_q;
  assign bp.MISS_COUNT = miss_cnt_q;

  always_comb begin
    ctr_d      = ctr_q;
    pred_cnt_d = pred_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.RES_VALID) begin
      if (br_is_cond(bp.RES_TYPE)) begin
        if (bp.RES_TAKEN && (ctr_q[res_idx] != ST))
          ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
        else if (!bp.RES_TAKEN && (ctr_q[res_idx] != SNT))
          ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
      end
      if (br_is_branch(bp.RES_TYPE)) begin
        if (pred_cnt_q != '1) pred_cnt_d = pred_cnt_q + STAT_W'(1);
        if (bp.RES_MISS && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
      pred_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      ctr_q      <= ctr_d;
      pred_cnt_q <= pred_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule
`default_nettype wire
